bcd_updown_counter_mod: RTL and testbench
=========================================

# bcd_updown_counter_mod

Parametrised, loadable two-digit BCD up/down counter with configurable modulus and selectable wrap or stop-at-limit behaviour. It generalises the fixed mod-60 loadable down counter so that one block covers the seconds and minutes (mod 60), hours (mod 24) and 00–99 stages of clock, stopwatch and timer designs. Stages cascade by feeding each stage's `dec_clk` into the next stage's `clk_time`.

## Interface
Parameters:
- `MODULUS`, default 60: count range 0..MODULUS-1. Legal range 2..100.
- `STOP_AT_LIMIT`, default 0: 0 = wrap at the terminal value; 1 = saturate at the terminal value.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset_p`  in  1  synchronous, active-high reset.
- `clk_time`  in  1  count strobe; one count per `clk` edge while high.
- `up_down`  in  1  1 = count up, 0 = count down; sampled with `clk_time`.
- `load_enable`  in  1  load request; sampled every edge.
- `set_value1`  in  4  BCD ones digit to load.
- `set_value10`  in  4  BCD tens digit to load.
- `dec1`  out  4  BCD ones digit, registered.
- `dec10`  out  4  BCD tens digit, registered.
- `dec_clk`  out  1  one-cycle wrap pulse: borrow when counting down, carry when counting up.
- `zero`  out  1  registered; high when the count is 00.
- `done`  out  1  one-cycle pulse on arrival at the terminal value (STOP_AT_LIMIT=1 only; tied 0 otherwise).
- `load_error`  out  1  one-cycle pulse when a load is rejected.

## Operation
- Priority on each edge: `reset_p` > `load_enable` > `clk_time`. Lower-priority inputs are ignored in that cycle.
- Reset values: dec1=0, dec10=0, dec_clk=0, done=0, load_error=0, zero=1.
- Load is accepted only if both digits are ≤ 9 and 10·set_value10 + set_value1 < MODULUS.
  - Accepted: the count takes the new value.
  - Rejected: the count is unchanged and `load_error` pulses.
  - A load never asserts `dec_clk` or `done`.
- Terminal values: LAST = MODULUS-1, split into LAST10 = LAST/10 and LAST1 = LAST%10. The terminal value is 00 when counting down and LAST when counting up.
- Down count:
  - If ones > 0: decrement ones.
  - Else if tens > 0: ones becomes 9 and tens decrements.
  - At 00 with STOP_AT_LIMIT=0: the count becomes LAST and `dec_clk` pulses.
  - At 00 with STOP_AT_LIMIT=1: the count holds and no pulse is generated.
- Up count:
  - At LAST with STOP_AT_LIMIT=0: the count becomes 00 and `dec_clk` pulses.
  - At LAST with STOP_AT_LIMIT=1: the count holds and no pulse is generated.
  - Else if ones == 9: ones becomes 0 and tens increments.
  - Else: increment ones.
- `done` (STOP_AT_LIMIT=1): pulses on the edge where a count step lands on the terminal value of the current direction. A load to the terminal value does not assert `done`.
- Out-of-range states cannot be reached, because loads are validated and reset goes to 00.
- A direction change takes effect at the next strobe. There is no pipeline state.

## Timing
- All outputs are registered. Digits, `zero`, `dec_clk`, `done` and `load_error` update on the same edge that samples the inputs: latency is 1 clk, with no combinational input-to-output path.
- `dec_clk` and `done` are high for exactly one clk, in the cycle after the causing edge. This aligns with the updated digits.
- Cascading: the next stage samples `dec_clk` as its `clk_time` one cycle after the wrap. The ripple delay is therefore 1 clk per stage.
- `clk_time` held high for N cycles produces N counts. The source must supply single-cycle strobes.
- Reset mid-count, including while `clk_time` or `load_enable` is high: state is 00 after that edge and all pulses are 0.

## Structure
- Shared package `counter_pkg` contains:
  - `BCD_W` = 4.
  - Function `is_bcd(digit)`.
  - Function `bcd_to_bin2(tens, ones)`, used for the load compare.
- Sub-module `bcd_digit_updown`: one decade with parametrised maximum digit (`MAX`, default 9), `en`, `up`, `load`, `d`, `q`, and a registered `wrap` output. It is instantiated twice.
- The top level contains:
  - the MODULUS terminal logic, i.e. the tens-digit limit and the ones-digit limit when tens == LAST10;
  - load validation;
  - STOP_AT_LIMIT gating;
  - the `dec_clk`, `done` and `zero` registers.

## Test plan
- MODULUS=60, load 35, down, 40 strobes.
  - Count runs 34 … 00, then 59.
  - `dec_clk` is high exactly once, on 00→59.
  - Final value is 55.
- MODULUS=60, load 58, up, 3 strobes.
  - Count runs 59, 00, 01.
  - `dec_clk` pulses once, on 59→00.
  - `zero` is high only while the count is 00.
- MODULUS=60, load 72, then load {0xA, 1}.
  - Each load produces one `load_error` pulse.
  - The count stays at its prior value.
  - `dec_clk` and `done` stay at 0.
- MODULUS=24, STOP_AT_LIMIT=1, load 02, down, 4 strobes.
  - Count runs 01, 00, 00, 00.
  - `done` pulses once, on 01→00.
  - `dec_clk` never asserts.
  - Switching to up and strobing gives 01.
- Simultaneous events, MODULUS=60, count 30:
  - `load_enable` with 12 together with `clk_time`: result is 12, with no decrement.
  - `reset_p` together with `clk_time` and `load_enable`: result is 00 and all pulses are 0.
- MODULUS=100, count 00, down: result is 99 with one `dec_clk` pulse. Up from 99: result is 00 with one `dec_clk` pulse.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared definitions for the BCD counter family: digit width and BCD helpers.
package counter_pkg;

  localparam int unsigned BCD_W = 4;

  function automatic logic is_bcd(input logic [BCD_W-1:0] digit);
    return digit <= 4'd9;
  endfunction

  // Wide enough for any pair of 4-bit digits, so illegal digits cannot alias.
  function automatic logic [7:0] bcd_to_bin2(input logic [BCD_W-1:0] tens,
                                             input logic [BCD_W-1:0] ones);
    return 8'(tens) * 8'd10 + 8'(ones);
  endfunction

endpackage

// File: rtl/bcd_digit_updown.sv
// One BCD decade counting 0..MAX in either direction, with a registered wrap pulse.
module bcd_digit_updown
  import counter_pkg::*;
#(
  parameter int unsigned MAX = 9
) (
  input  logic             clk,
  input  logic             reset_p,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [BCD_W-1:0] d,
  output logic [BCD_W-1:0] q,
  output logic             wrap
);

  localparam logic [BCD_W-1:0] MAX_D = BCD_W'(MAX);

  always_ff @(posedge clk) begin
    if (reset_p) begin
      q    <= '0;
      wrap <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (load) begin
        q <= d;
      end else if (en) begin
        if (up) begin
          if (q == MAX_D) begin
            q    <= '0;
            wrap <= 1'b1;
          end else begin
            q <= q + 1'b1;
          end
        end else begin
          if (q == '0) begin
            q    <= MAX_D;
            wrap <= 1'b1;
          end else begin
            q <= q - 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/bcd_updown_counter_mod.sv
// Loadable two-digit BCD up/down counter with configurable modulus and wrap/stop behaviour.
module bcd_updown_counter_mod
  import counter_pkg::*;
#(
  parameter int unsigned MODULUS       = 60,
  parameter bit          STOP_AT_LIMIT = 1'b0
) (
  input  logic             clk,
  input  logic             reset_p,
  input  logic             clk_time,
  input  logic             up_down,
  input  logic             load_enable,
  input  logic [BCD_W-1:0] set_value1,
  input  logic [BCD_W-1:0] set_value10,
  output logic [BCD_W-1:0] dec1,
  output logic [BCD_W-1:0] dec10,
  output logic             dec_clk,
  output logic             zero,
  output logic             done,
  output logic             load_error
);

  localparam int unsigned      LAST   = MODULUS - 1;
  localparam logic [7:0]       LAST_B = 8'(LAST);
  localparam logic [BCD_W-1:0] LAST10 = BCD_W'(LAST / 10);
  localparam logic [BCD_W-1:0] LAST1  = BCD_W'(LAST % 10);

  logic [7:0]       count_b;
  logic             at_last, at_zero, load_ok;
  logic             step, hold, advance, term_wrap, lands;
  logic             ones_load, ones_en, tens_load, tens_en;
  logic [BCD_W-1:0] ones_d;
  logic             ones_wrap_unused;
  logic             zero_nxt;

  always_comb begin
    count_b   = bcd_to_bin2(dec10, dec1);
    at_last   = (count_b == LAST_B);
    at_zero   = (count_b == '0);
    load_ok   = is_bcd(set_value10) && is_bcd(set_value1) &&
                (bcd_to_bin2(set_value10, set_value1) <= LAST_B);

    step      = clk_time && !load_enable;
    hold      = STOP_AT_LIMIT && (up_down ? at_last : at_zero);
    advance   = step && !hold;
    term_wrap = advance && (up_down ? at_last : at_zero);
    lands     = advance && !term_wrap &&
                (up_down ? (count_b == LAST_B - 8'd1) : (count_b == 8'd1));

    // Terminal wrap forces the ones digit (LAST1 may not be 9); tens wraps
    // naturally at LAST10, so its wrap pulse is exactly the stage carry/borrow.
    ones_load = (load_enable && load_ok) || term_wrap;
    ones_d    = load_enable ? set_value1 : (up_down ? '0 : LAST1);
    ones_en   = advance;
    tens_load = load_enable && load_ok;
    tens_en   = advance && (up_down ? ((dec1 == 4'd9) || at_last) : (dec1 == '0));

    zero_nxt = zero;
    if (load_enable) begin
      if (load_ok) zero_nxt = (set_value10 == '0) && (set_value1 == '0);
    end else if (advance) begin
      zero_nxt = up_down ? term_wrap : (count_b == 8'd1);
    end
  end

  bcd_digit_updown #(.MAX(9)) u_ones (
    .clk     (clk),
    .reset_p (reset_p),
    .en      (ones_en),
    .up      (up_down),
    .load    (ones_load),
    .d       (ones_d),
    .q       (dec1),
    .wrap    (ones_wrap_unused)
  );

  bcd_digit_updown #(.MAX(LAST / 10)) u_tens (
    .clk     (clk),
    .reset_p (reset_p),
    .en      (tens_en),
    .up      (up_down),
    .load    (tens_load),
    .d       (set_value10),
    .q       (dec10),
    .wrap    (dec_clk)
  );

  always_ff @(posedge clk) begin
    if (reset_p) begin
      zero       <= 1'b1;
      done       <= 1'b0;
      load_error <= 1'b0;
    end else begin
      zero       <= zero_nxt;
      done       <= STOP_AT_LIMIT && lands;
      load_error <= load_enable && !load_ok;
    end
  end

endmodule

// File: tb/tb_bcd_updown_counter_mod.sv
// Self-checking bench: three counter configurations driven in parallel against an arithmetic model.
module tb_bcd_updown_counter_mod;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_p, clk_time, up_down, load_enable;
  logic [3:0] set_value1, set_value10;

  logic [3:0] a_dec1, a_dec10, b_dec1, b_dec10, c_dec1, c_dec10;
  logic       a_dec_clk, a_zero, a_done, a_load_error;
  logic       b_dec_clk, b_zero, b_done, b_load_error;
  logic       c_dec_clk, c_zero, c_done, c_load_error;

  bcd_updown_counter_mod #(.MODULUS(60), .STOP_AT_LIMIT(1'b0)) dut_m60 (
    .clk(clk), .reset_p(reset_p), .clk_time(clk_time), .up_down(up_down),
    .load_enable(load_enable), .set_value1(set_value1), .set_value10(set_value10),
    .dec1(a_dec1), .dec10(a_dec10), .dec_clk(a_dec_clk), .zero(a_zero),
    .done(a_done), .load_error(a_load_error));

  bcd_updown_counter_mod #(.MODULUS(24), .STOP_AT_LIMIT(1'b1)) dut_m24 (
    .clk(clk), .reset_p(reset_p), .clk_time(clk_time), .up_down(up_down),
    .load_enable(load_enable), .set_value1(set_value1), .set_value10(set_value10),
    .dec1(b_dec1), .dec10(b_dec10), .dec_clk(b_dec_clk), .zero(b_zero),
    .done(b_done), .load_error(b_load_error));

  bcd_updown_counter_mod #(.MODULUS(100), .STOP_AT_LIMIT(1'b0)) dut_m100 (
    .clk(clk), .reset_p(reset_p), .clk_time(clk_time), .up_down(up_down),
    .load_enable(load_enable), .set_value1(set_value1), .set_value10(set_value10),
    .dec1(c_dec1), .dec10(c_dec10), .dec_clk(c_dec_clk), .zero(c_zero),
    .done(c_done), .load_error(c_load_error));

  // Observed vector per DUT: {tens, ones, dec_clk, zero, done, load_error}
  logic [11:0] obs [3];
  assign obs[0] = {a_dec10, a_dec1, a_dec_clk, a_zero, a_done, a_load_error};
  assign obs[1] = {b_dec10, b_dec1, b_dec_clk, b_zero, b_done, b_load_error};
  assign obs[2] = {c_dec10, c_dec1, c_dec_clk, c_zero, c_done, c_load_error};

  int mod_k  [3] = '{60, 24, 100};
  bit stop_k [3] = '{1'b0, 1'b1, 1'b0};
  int mv     [3];
  bit mdc    [3];
  bit mdone  [3];
  bit merr   [3];

  int errors = 0;
  int checks = 0;

  function automatic logic [11:0] expect_of(int k);
    return {4'(mv[k] / 10), 4'(mv[k] % 10), mdc[k], (mv[k] == 0), mdone[k], merr[k]};
  endfunction

  task automatic cycle(input bit r, input bit ld, input bit ct, input bit ud,
                       input logic [3:0] s10, input logic [3:0] s1);
    int val;
    reset_p = r; load_enable = ld; clk_time = ct; up_down = ud;
    set_value10 = s10; set_value1 = s1;
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      mdc[k] = 1'b0; mdone[k] = 1'b0; merr[k] = 1'b0;
      if (r) begin
        mv[k] = 0;
      end else if (ld) begin
        val = int'(s10) * 10 + int'(s1);
        if (s10 <= 9 && s1 <= 9 && val < mod_k[k]) mv[k] = val;
        else merr[k] = 1'b1;
      end else if (ct) begin
        if (ud) begin
          if (mv[k] == mod_k[k] - 1) begin
            if (!stop_k[k]) begin mv[k] = 0; mdc[k] = 1'b1; end
          end else begin
            mv[k] = mv[k] + 1;
            mdone[k] = stop_k[k] && (mv[k] == mod_k[k] - 1);
          end
        end else begin
          if (mv[k] == 0) begin
            if (!stop_k[k]) begin mv[k] = mod_k[k] - 1; mdc[k] = 1'b1; end
          end else begin
            mv[k] = mv[k] - 1;
            mdone[k] = stop_k[k] && (mv[k] == 0);
          end
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    cycle(1, 1, 1, 1, 4'd3, 4'd3);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs[k] !== expect_of(k)) begin
        errors++;
        $display("FAIL reset dut%0d got=%h want=%h", k, obs[k], expect_of(k));
      end
    end
    checks++;
    if (obs[0] !== 12'h004) begin
      errors++;
      $display("FAIL reset_const got=%h want=004", obs[0]);
    end
  endtask

  task automatic test_down_wrap();
    int pulses;
    pulses = 0;
    cycle(0, 1, 0, 0, 4'd3, 4'd5);
    for (int i = 0; i < 40; i++) begin
      cycle(0, 0, 1, 0, 4'd0, 4'd0);
      if (a_dec_clk) pulses++;
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs[k] !== expect_of(k)) begin
          errors++;
          $display("FAIL down_wrap step%0d dut%0d got=%h want=%h", i, k, obs[k], expect_of(k));
        end
      end
    end
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL down_wrap_pulses got=%0d want=1", pulses);
    end
    checks++;
    if ({a_dec10, a_dec1} !== 8'h55) begin
      errors++;
      $display("FAIL down_wrap_final got=%h want=55", {a_dec10, a_dec1});
    end
  endtask

  task automatic test_up_wrap();
    int zeros;
    zeros = 0;
    cycle(0, 1, 0, 1, 4'd5, 4'd8);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 1, 1, 4'd0, 4'd0);
      if (a_zero) zeros++;
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs[k] !== expect_of(k)) begin
          errors++;
          $display("FAIL up_wrap step%0d dut%0d got=%h want=%h", i, k, obs[k], expect_of(k));
        end
      end
    end
    checks++;
    if (zeros !== 1 || {a_dec10, a_dec1} !== 8'h01) begin
      errors++;
      $display("FAIL up_wrap_final got=%h zeros=%0d want=01 zeros=1", {a_dec10, a_dec1}, zeros);
    end
  endtask

  task automatic test_load_error();
    logic [3:0] bad10 [2] = '{4'd7, 4'hA};
    logic [3:0] bad1  [2] = '{4'd2, 4'd1};
    for (int i = 0; i < 2; i++) begin
      cycle(0, 1, 0, 0, bad10[i], bad1[i]);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs[k] !== expect_of(k)) begin
          errors++;
          $display("FAIL load_error%0d dut%0d got=%h want=%h", i, k, obs[k], expect_of(k));
        end
      end
      checks++;
      if (obs[0] !== 12'h011) begin
        errors++;
        $display("FAIL load_error_const%0d got=%h want=011", i, obs[0]);
      end
    end
  endtask

  task automatic test_stop();
    int dones, carries;
    dones = 0; carries = 0;
    cycle(0, 1, 0, 0, 4'd0, 4'd2);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 1, 0, 4'd0, 4'd0);
      if (b_done) dones++;
      if (b_dec_clk) carries++;
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs[k] !== expect_of(k)) begin
          errors++;
          $display("FAIL stop step%0d dut%0d got=%h want=%h", i, k, obs[k], expect_of(k));
        end
      end
    end
    checks++;
    if (dones !== 1 || carries !== 0) begin
      errors++;
      $display("FAIL stop_pulses got done=%0d dec_clk=%0d want 1 and 0", dones, carries);
    end
    cycle(0, 0, 1, 1, 4'd0, 4'd0);
    checks++;
    if (obs[1] !== 12'h010) begin
      errors++;
      $display("FAIL stop_up got=%h want=010", obs[1]);
    end
  endtask

  task automatic test_priority();
    cycle(0, 1, 0, 0, 4'd3, 4'd0);
    cycle(0, 1, 1, 0, 4'd1, 4'd2);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs[k] !== expect_of(k)) begin
        errors++;
        $display("FAIL prio_load dut%0d got=%h want=%h", k, obs[k], expect_of(k));
      end
    end
    checks++;
    if (obs[0] !== 12'h120) begin
      errors++;
      $display("FAIL prio_load_const got=%h want=120", obs[0]);
    end
    cycle(0, 1, 0, 0, 4'd3, 4'd0);
    cycle(1, 1, 1, 0, 4'd1, 4'd2);
    checks++;
    if (obs[0] !== 12'h004 || obs[1] !== 12'h004 || obs[2] !== 12'h004) begin
      errors++;
      $display("FAIL prio_reset got=%h %h %h want=004", obs[0], obs[1], obs[2]);
    end
  endtask

  task automatic test_mod100();
    cycle(1, 0, 0, 0, 4'd0, 4'd0);
    cycle(0, 0, 1, 0, 4'd0, 4'd0);
    checks++;
    if (obs[2] !== 12'h998) begin
      errors++;
      $display("FAIL mod100_down got=%h want=998", obs[2]);
    end
    cycle(0, 0, 1, 1, 4'd0, 4'd0);
    checks++;
    if (obs[2] !== 12'h00C) begin
      errors++;
      $display("FAIL mod100_up got=%h want=00c", obs[2]);
    end
  endtask

  task automatic test_random();
    bit r, ld, ct, ud;
    logic [3:0] s10, s1;
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 39) == 0);
      ld = ($urandom_range(0, 7) == 0);
      ct = ($urandom_range(0, 3) != 0);
      ud = ($urandom_range(0, 1) == 1);
      s10 = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      s1  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      cycle(r, ld, ct, ud, s10, s1);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs[k] !== expect_of(k)) begin
          errors++;
          $display("FAIL random%0d dut%0d got=%h want=%h", i, k, obs[k], expect_of(k));
        end
      end
    end
  endtask

  initial begin
    reset_p = 1'b1; clk_time = 1'b0; up_down = 1'b0; load_enable = 1'b0;
    set_value1 = '0; set_value10 = '0;
    for (int k = 0; k < 3; k++) begin
      mv[k] = 0; mdc[k] = 1'b0; mdone[k] = 1'b0; merr[k] = 1'b0;
    end
    test_reset();
    test_down_wrap();
    test_up_wrap();
    test_load_error();
    test_stop();
    test_priority();
    test_mod100();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
